// File: rtl/jt6295_chfeed.sv
// Four-voice ADPCM feeder: ROM byte fetch, nibble split, slot rotation.
// Optional sticky underrun flags: define JT6295_UNDERRUN_EN.
module jt6295_chfeed #(
   parameter int AW  = 18,
   parameter int CHN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          start,
   input  logic [1:0]    start_ch,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] stop_addr,
   input  logic [3:0]    start_att,
   input  logic [3:0]    stop,
   output logic [3:0]    busy,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [7:0]    rom_data,
   output logic [3:0]    data,
   output logic          en,
   output logic [3:0]    att,
   output logic [1:0]    ch,
   output logic [3:0]    underrun
);

   typedef enum logic { IDLE, REQ } st_t;

   st_t            st;
   logic [AW-1:0]  addr  [CHN];
   logic [AW-1:0]  last  [CHN];
   logic [3:0]     vatt  [CHN];
   logic [7:0]     bytes [CHN];
   logic [CHN-1:0] valid;
   logic [CHN-1:0] nib;
   logic [1:0]     lst;
   logic [1:0]     fch;
   logic [1:0]     nch;
   logic [1:0]     idx;
   logic [1:0]     pick;
   logic           found;
   logic           stale;
   logic           hit_s;
   logic           hit_f;

`ifdef JT6295_UNDERRUN_EN
   logic [3:0] ur;
   assign underrun = ur;
`else
   assign underrun = '0;
`endif

   assign nch   = ch + 2'd1;
   assign hit_s = start && (start_ch == nch);
   // a start/stop on the voice being fetched makes its reply stale
   assign hit_f = (start && (start_ch == fch)) || stop[fch];

   always_comb begin
      found = 1'b0;
      pick  = lst;
      idx   = lst;
      for (int i = 1; i <= CHN; i++) begin
         idx = lst + 2'(i);
         if (!found && busy[idx] && !valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st       <= IDLE;
         busy     <= '0;
         valid    <= '0;
         nib      <= '0;
         data     <= '0;
         en       <= 1'b0;
         att      <= '0;
         ch       <= 2'd3;
         rom_cs   <= 1'b0;
         rom_addr <= '0;
         lst      <= 2'd3;
         fch      <= 2'd0;
         stale    <= 1'b0;
         for (int i = 0; i < CHN; i++) begin
            addr[i]  <= '0;
            last[i]  <= '0;
            vatt[i]  <= '0;
            bytes[i] <= '0;
         end
`ifdef JT6295_UNDERRUN_EN
         ur <= '0;
`endif
      end else begin
         case (st)
            IDLE: begin
               if (found) begin
                  rom_addr <= addr[pick];
                  rom_cs   <= 1'b1;
                  fch      <= pick;
                  lst      <= pick;
                  stale    <= (start && (start_ch == pick)) || stop[pick];
                  st       <= REQ;
               end
            end
            REQ: begin
               if (hit_f) stale <= 1'b1;
               if (rom_ok) begin
                  rom_cs <= 1'b0;
                  st     <= IDLE;
                  if (!stale && !hit_f) begin
                     bytes[fch] <= rom_data;
                     valid[fch] <= 1'b1;
                     nib[fch]   <= 1'b0;
                  end
               end
            end
         endcase

         if (cen) begin
            ch  <= nch;
            att <= vatt[nch];
            if (hit_s || !busy[nch] || stop[nch]) begin
               en   <= 1'b0;
               data <= '0;
            end else begin
               en <= 1'b1;
               if (valid[nch]) begin
                  data <= nib[nch] ? bytes[nch][3:0] : bytes[nch][7:4];
                  if (nib[nch]) begin
                     valid[nch] <= 1'b0;
                     nib[nch]   <= 1'b0;
                     if (addr[nch] == last[nch]) busy[nch] <= 1'b0;
                     else addr[nch] <= addr[nch] + AW'(1);
                  end else begin
                     nib[nch] <= 1'b1;
                  end
               end else begin
                  data <= '0;
`ifdef JT6295_UNDERRUN_EN
                  ur[nch] <= 1'b1;
`endif
               end
            end
         end

         // control last so start beats stop, slot and fetch updates
         for (int i = 0; i < CHN; i++) begin
            if (stop[i]) busy[i] <= 1'b0;
         end
         if (start) begin
            addr[start_ch]  <= start_addr;
            last[start_ch]  <= stop_addr;
            vatt[start_ch]  <= start_att;
            busy[start_ch]  <= 1'b1;
            valid[start_ch] <= 1'b0;
            nib[start_ch]   <= 1'b0;
`ifdef JT6295_UNDERRUN_EN
            ur[start_ch] <= 1'b0;
`endif
         end
      end
   end

endmodule
